// File: rtl/dma_pea_xbar_sched.sv
// DMA-to-PEA input-stream crossbar sequencer.
// Holds a table of crossbar configurations (sel vector plus repeat count per entry), steps
// through the active entries, drives the crossbar sel lines and pops the DMA channels that
// each accepted beat consumes.
// Optional build macro: DMA_PEA_SCHED_LOOP_EN adds loop_i. When loop_i is latched high at
// start, the sequence wraps back to entry 0 and keeps running until stop_i.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; sel_o and cfg_idx_o hold their last values
// RUN   | stepping through table entries, one transfer per fire
// DONE  | one-cycle done_o pulse, then back to IDLE
module dma_pea_xbar_sched #(
   parameter  int N_DMA_CH  = 4,
   parameter  int N_PEA_DIN = 4,
   parameter  int N_CFG     = 8,
   parameter  int CNT_W     = 16,
   localparam int SEL_W     = $clog2(N_DMA_CH),
   localparam int AW        = $clog2(N_CFG)
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       cfg_we_i,
   input  logic [AW-1:0]              cfg_addr_i,
   input  logic [N_PEA_DIN*SEL_W-1:0] cfg_sel_i,
   input  logic [CNT_W-1:0]           cfg_rep_i,
   input  logic [AW:0]                n_cfg_i,
   input  logic                       start_i,
   input  logic                       stop_i,
`ifdef DMA_PEA_SCHED_LOOP_EN
   input  logic                       loop_i,
`endif
   input  logic [N_DMA_CH-1:0]        dma_ch_valid_i,
   input  logic                       pea_ready_i,
   output logic [N_DMA_CH-1:0]        dma_ch_ready_o,
   output logic [N_PEA_DIN*SEL_W-1:0] sel_o,
   output logic                       fire_o,
   output logic [AW-1:0]              cfg_idx_o,
   output logic                       busy_o,
   output logic                       done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state_q, state_d;
   logic [N_PEA_DIN*SEL_W-1:0]   tbl_sel [N_CFG];
   logic [CNT_W-1:0]             tbl_rep [N_CFG];
   logic [N_PEA_DIN*SEL_W-1:0]   sel_q;
   logic [CNT_W-1:0]             rep_q;
   logic [CNT_W-1:0]             cnt_q;
   logic [AW-1:0]                idx_q;
   logic [AW-1:0]                idx_nxt;
   logic [AW:0]                  ncfg_q;
   logic [AW:0]                  n_eff;
   logic                         loop_q;
   logic [N_DMA_CH-1:0]          need;
   logic                         fire;
   logic                         last_entry;
   logic                         start_ok;
   logic                         load_first;
   logic                         load_next;
   logic                         cnt_inc;

   assign n_eff      = (n_cfg_i > (AW+1)'(N_CFG)) ? (AW+1)'(N_CFG) : n_cfg_i;
   assign idx_nxt    = idx_q + AW'(1);
   assign last_entry = ({1'b0, idx_q} == (ncfg_q - (AW+1)'(1)));
   assign start_ok   = (state_q == IDLE) && start_i;

   // Configuration table; writable in any state, cleared by reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < N_CFG; i++) begin
            tbl_sel[i] <= '0;
            tbl_rep[i] <= '0;
         end
      end else if (cfg_we_i) begin
         tbl_sel[cfg_addr_i] <= cfg_sel_i;
         tbl_rep[cfg_addr_i] <= cfg_rep_i;
      end
   end

   // Set of channels referenced by the active sel vector; shared channels pop once.
   always_comb begin
      need = '0;
      for (int i = 0; i < N_PEA_DIN; i++) begin
         need[sel_q[i*SEL_W +: SEL_W]] = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state and transfer decode; the counter compares before it increments.
   always_comb begin
      state_d    = state_q;
      fire       = 1'b0;
      load_first = 1'b0;
      load_next  = 1'b0;
      cnt_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (n_eff != '0) begin
                  state_d    = RUN;
                  load_first = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            fire = ~stop_i & pea_ready_i & (&(dma_ch_valid_i | ~need));
            if (stop_i) begin
               state_d = IDLE;
            end else if (fire) begin
               if (cnt_q != rep_q)  cnt_inc    = 1'b1;
               else if (!last_entry) load_next = 1'b1;
               else if (loop_q)     load_first = 1'b1;
               else                 state_d    = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Active entry copy, entry index and repeat counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q  <= '0;
         rep_q  <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         ncfg_q <= '0;
      end else begin
         if (start_ok) ncfg_q <= n_eff;
         if (load_first) begin
            sel_q <= tbl_sel[0];
            rep_q <= tbl_rep[0];
            idx_q <= '0;
            cnt_q <= '0;
         end else if (load_next) begin
            sel_q <= tbl_sel[idx_nxt];
            rep_q <= tbl_rep[idx_nxt];
            idx_q <= idx_nxt;
            cnt_q <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef DMA_PEA_SCHED_LOOP_EN
   // Loop mode is latched at start so it cannot change mid-sequence.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      loop_q <= 1'b0;
      else if (start_ok) loop_q <= loop_i;
   end
`else
   assign loop_q = 1'b0;
`endif

   assign fire_o         = fire;
   assign dma_ch_ready_o = need & {N_DMA_CH{fire}};
   assign sel_o          = sel_q;
   assign cfg_idx_o      = idx_q;
   assign busy_o         = (state_q == RUN);
   assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_dma_pea_xbar_sched.sv
// Scoreboard bench for dma_pea_xbar_sched: each start expands the shadow table into the
// expected list of transfers (plus a done marker); a negedge monitor pops and compares.
module tb_dma_pea_xbar_sched;
   localparam int NCH  = 4;
   localparam int NPD  = 4;
   localparam int NCFG = 8;
   localparam int CW   = 4;
   localparam int SW   = 2;
   localparam int AW   = 3;
   localparam int SELT = NPD*SW;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic            cfg_we_i = 1'b0;
   logic [AW-1:0]   cfg_addr_i = '0;
   logic [SELT-1:0] cfg_sel_i = '0;
   logic [CW-1:0]   cfg_rep_i = '0;
   logic [AW:0]     n_cfg_i = '0;
   logic            start_i = 1'b0;
   logic            stop_i = 1'b0;
`ifdef DMA_PEA_SCHED_LOOP_EN
   logic            loop_i = 1'b0;
`endif
   logic [NCH-1:0]  dma_ch_valid_i = '1;
   logic            pea_ready_i = 1'b1;
   logic [NCH-1:0]  dma_ch_ready_o;
   logic [SELT-1:0] sel_o;
   logic            fire_o;
   logic [AW-1:0]   cfg_idx_o;
   logic            busy_o;
   logic            done_o;

   dma_pea_xbar_sched #(.N_DMA_CH(NCH), .N_PEA_DIN(NPD), .N_CFG(NCFG), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
      .cfg_sel_i(cfg_sel_i), .cfg_rep_i(cfg_rep_i), .n_cfg_i(n_cfg_i), .start_i(start_i),
      .stop_i(stop_i),
`ifdef DMA_PEA_SCHED_LOOP_EN
      .loop_i(loop_i),
`endif
      .dma_ch_valid_i(dma_ch_valid_i), .pea_ready_i(pea_ready_i),
      .dma_ch_ready_o(dma_ch_ready_o), .sel_o(sel_o), .fire_o(fire_o),
      .cfg_idx_o(cfg_idx_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit             is_done;
      int             idx;
      logic [SELT-1:0] sel;
      logic [NCH-1:0] mask;
   } item_t;

   item_t           q[$];
   logic [SELT-1:0] sh_sel [NCFG];
   int              sh_rep [NCFG];
   int              checks = 0;
   int              errors = 0;
   int              fires = 0;
   bit              done_seen = 0;
   bit              exp_done = 0;
   logic [SELT-1:0] last_sel = '0;
   int              last_idx = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Channels a sel vector references: each PEA input names one channel.
   function automatic logic [NCH-1:0] need_of(input logic [SELT-1:0] s);
      logic [NCH-1:0] m = '0;
      for (int i = 0; i < NPD; i++) m = m | (NCH'(1) << s[i*SW +: SW]);
      return m;
   endfunction

   function automatic void build_queue(input int n, input bit lp);
      item_t it;
      int ne = (n > NCFG) ? NCFG : n;
      int laps = lp ? 8 : 1;
      for (int l = 0; l < laps; l++)
         for (int e = 0; e < ne; e++)
            for (int r = 0; r <= sh_rep[e]; r++) begin
               it.is_done = 0; it.idx = e; it.sel = sh_sel[e]; it.mask = need_of(sh_sel[e]);
               q.push_back(it);
            end
      if (!lp) begin
         it.is_done = 1; it.idx = 0; it.sel = '0; it.mask = '0;
         q.push_back(it);
      end
   endfunction

   function automatic void flush();
      if (q.size() > 0 && !q[0].is_done) begin
         last_sel = q[0].sel;
         last_idx = q[0].idx;
      end
      q.delete();
      exp_done = 0;
   endfunction

   // Monitor: compares every sampled cycle against the head of the expected list.
   always @(negedge clk_i) begin
      item_t it;
      logic exp_fire;
      if (rst_n_i) begin
         if (exp_done) begin
            chk("done_after_last_fire", done_o, 1);
            chk("busy_drops_with_done", busy_o, 0);
            exp_done = 0;
         end
         if (q.size() > 0 && !q[0].is_done) begin
            chk("busy_run", busy_o, 1);
            chk("sel", sel_o, q[0].sel);
            chk("cfg_idx", cfg_idx_o, q[0].idx);
            exp_fire = !stop_i && pea_ready_i && ((dma_ch_valid_i | ~q[0].mask) == '1);
            chk("fire", fire_o, exp_fire);
            if (fire_o) begin
               chk("pop_mask", dma_ch_ready_o, q[0].mask);
               it = q.pop_front();
               fires++;
               last_sel = it.sel;
               last_idx = it.idx;
               if (q.size() > 0 && q[0].is_done) exp_done = 1;
            end else begin
               chk("no_pop", dma_ch_ready_o, 0);
            end
         end else begin
            chk("idle_fire", fire_o, 0);
            chk("idle_pop", dma_ch_ready_o, 0);
            if (done_o) begin
               if (q.size() > 0) begin
                  it = q.pop_front();
                  done_seen = 1;
               end else begin
                  chk("unexpected_done", done_o, 0);
               end
            end else if (!busy_o) begin
               chk("hold_sel", sel_o, last_sel);
               chk("hold_idx", cfg_idx_o, last_idx);
            end
         end
      end
   end

   task automatic wr(input int a, input logic [SELT-1:0] s, input int r);
      cfg_we_i = 1; cfg_addr_i = AW'(a); cfg_sel_i = s; cfg_rep_i = CW'(r);
      sh_sel[a] = s; sh_rep[a] = r;
      @(posedge clk_i); #1;
      cfg_we_i = 0;
   endtask

   task automatic run_seq(input int n, input bit lp, input int stop_at, input bit rnd,
                          input bit ss);
      int  f0;
      int  cyc;
      bit  aborted;
      done_seen = 0;
      n_cfg_i = (AW+1)'(n);
      start_i = 1; stop_i = ss;
`ifdef DMA_PEA_SCHED_LOOP_EN
      loop_i = lp;
`endif
      dma_ch_valid_i = '1; pea_ready_i = 1;
      @(posedge clk_i); #1;
      start_i = 0; stop_i = 0;
      build_queue(n, lp);
      f0 = fires;
      for (cyc = 0; cyc < 300; cyc++) begin
         if (done_seen && q.size() == 0) break;
         if (rnd) begin
            dma_ch_valid_i = NCH'($urandom);
            pea_ready_i = ($urandom % 4) != 0;
            start_i = busy_o && (($urandom % 8) == 0);
            n_cfg_i = (AW+1)'($urandom);
            if (!lp && ($urandom % 6) == 0) begin
               cfg_we_i = 1; cfg_addr_i = '0; cfg_sel_i = SELT'($urandom);
               cfg_rep_i = CW'($urandom % 3);
               sh_sel[0] = cfg_sel_i; sh_rep[0] = int'(cfg_rep_i);
            end
            stop_i = busy_o && (($urandom % 40) == 0);
         end
         if (stop_at >= 0 && (fires - f0) >= stop_at) stop_i = 1;
         aborted = stop_i && busy_o;
         @(posedge clk_i); #1;
         stop_i = 0; start_i = 0; cfg_we_i = 0;
         if (aborted) begin
            chk("stop_to_idle", busy_o, 0);
            chk("stop_no_done", done_o, 0);
            flush();
            break;
         end
      end
      if (cyc >= 300) begin
         checks++; errors++;
         $display("FAIL seq_timeout: got no completion expected done within 300 cycles");
         flush();
      end
`ifdef DMA_PEA_SCHED_LOOP_EN
      loop_i = 0;
`endif
      dma_ch_valid_i = '1; pea_ready_i = 1;
      @(posedge clk_i); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sel"}, sel_o, 0);
      chk({tag, "_idx"}, cfg_idx_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_fire"}, fire_o, 0);
      chk({tag, "_pop"}, dma_ch_ready_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int i = 0; i < NCFG; i++) begin sh_sel[i] = '0; sh_rep[i] = 0; end
      #3;
      check_reset_outputs("rst");
      @(posedge clk_i); #3;
      rst_n_i = 1;
      @(posedge clk_i); #1;

      // four fires of a full-fanout entry
      wr(0, 8'hE4, 3);
      run_seq(1, 0, -1, 0, 0);
      // shared channels then a single channel across two entries, no bubble
      wr(0, 8'h50, 0);
      wr(1, 8'hAA, 1);
      run_seq(2, 0, -1, 0, 0);
      // maximum repeat count
      wr(0, 8'h1B, 15);
      run_seq(1, 0, -1, 0, 0);
      // stop on a would-be fire
      wr(0, 8'hE4, 3);
      run_seq(1, 0, 2, 0, 0);
      // start and stop together in IDLE: start wins
      run_seq(1, 0, -1, 0, 1);
      // empty sequence
      run_seq(0, 0, -1, 0, 0);
      // n_cfg above table depth clamps
      for (int i = 0; i < NCFG; i++) wr(i, SELT'($urandom), i % 2);
      run_seq(12, 0, -1, 0, 0);
`ifdef DMA_PEA_SCHED_LOOP_EN
      wr(0, 8'h00, 0);
      wr(1, 8'hFF, 0);
      run_seq(2, 1, 5, 0, 0);
`endif

      // asynchronous reset while on entry 2
      for (int i = 0; i < 4; i++) wr(i, SELT'($urandom), 2);
      n_cfg_i = 4; start_i = 1;
      @(posedge clk_i); #1;
      start_i = 0;
      build_queue(4, 0);
      for (c = 0; c < 50 && cfg_idx_o != 2; c++) begin @(posedge clk_i); #1; end
      chk("reach_idx2", cfg_idx_o, 2);
      #2 rst_n_i = 0;
      #1 check_reset_outputs("async_rst");
      q.delete(); exp_done = 0; last_sel = '0; last_idx = 0;
      for (int i = 0; i < NCFG; i++) begin sh_sel[i] = '0; sh_rep[i] = 0; end
      @(posedge clk_i); #3;
      rst_n_i = 1;
      @(posedge clk_i); #1;
      run_seq(1, 0, -1, 0, 0);

      // randomized sequences
      for (int t = 0; t < 25; t++) begin
         for (int k = 0; k < 3; k++) wr($urandom % NCFG, SELT'($urandom), $urandom % 3);
         run_seq($urandom_range(0, 11), 0, -1, 1, 0);
      end

      repeat (3) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
